// File: rtl/fifo_rd_pkg.sv
// Shared definitions for the async FIFO pointer logic: default sizing and the
// Gray/binary conversions used by both the read-side and write-side controllers.
package fifo_rd_pkg;

  localparam int P_SIZE_DEFAULT   = 4;
  localparam int AE_LEVEL_DEFAULT = 1;

  // Conversions work on a wide word so any pointer width can share them;
  // callers zero-extend in and size-cast out, and the zero upper bits are inert.
  localparam int GRAY_MAX_W = 32;
  typedef logic [GRAY_MAX_W-1:0] gray_word_t;

  function automatic gray_word_t bin2gray(input gray_word_t bin);
    return bin ^ (bin >> 1);
  endfunction

  function automatic gray_word_t gray2bin(input gray_word_t gray);
    gray_word_t bin;
    bin[GRAY_MAX_W-1] = gray[GRAY_MAX_W-1];
    for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/fifo_rd_if.sv
// Read-side port bundle of the async FIFO: the read request and synchronized
// write pointer coming in, addressing, Gray pointer and status flags going out.
interface fifo_rd_if
  import fifo_rd_pkg::*;
#(
  parameter int P_SIZE = P_SIZE_DEFAULT
) ();

  logic              r_inc;
  logic [P_SIZE-1:0] sync_wr_ptr;
  logic [P_SIZE-2:0] r_addr;
  logic [P_SIZE-1:0] gray_rd_ptr;
  logic              empty;
  logic              almost_empty;
  logic [P_SIZE-1:0] rd_count;
  logic              underflow;

  // The reader client and the writer's synchronizer side of the bundle.
  modport master (
    output r_inc, sync_wr_ptr,
    input  r_addr, gray_rd_ptr, empty, almost_empty, rd_count, underflow
  );

  // The read-side controller itself.
  modport slave (
    input  r_inc, sync_wr_ptr,
    output r_addr, gray_rd_ptr, empty, almost_empty, rd_count, underflow
  );

endinterface

// File: rtl/fifo_gray2bin.sv
// Purely combinational Gray-to-binary converter of a W-bit pointer; shared by
// the read and write controllers for their occupancy arithmetic.
module fifo_gray2bin
  import fifo_rd_pkg::*;
#(
  parameter int W = P_SIZE_DEFAULT
) (
  input  logic [W-1:0] gray,
  output logic [W-1:0] bin
);

  assign bin = W'(gray2bin(gray_word_t'(gray)));

endmodule

// File: rtl/fifo_rd.sv
// Read-side controller of the async FIFO: owns the binary read pointer and
// derives empty/almost-empty/occupancy/underflow from the synchronized write pointer.
module fifo_rd
  import fifo_rd_pkg::*;
#(
  parameter int P_SIZE   = P_SIZE_DEFAULT,
  parameter int AE_LEVEL = AE_LEVEL_DEFAULT
) (
  input  logic     r_clk,
  input  logic     r_rstn,
  fifo_rd_if.slave rd
);

  typedef logic [P_SIZE-1:0] ptr_t;

  localparam ptr_t PTR_ONE   = ptr_t'(1);
  localparam ptr_t AE_THRESH = ptr_t'(AE_LEVEL);

  ptr_t r_ptr_q, r_ptr_d;
  ptr_t gray_q, gray_d;
  ptr_t count_q, count_d;
  logic underflow_q, underflow_d;

  ptr_t comb_gray;
  ptr_t wr_bin;
  ptr_t comb_count;
  logic empty_c;
  logic rd_accept;

  fifo_gray2bin #(
    .W (P_SIZE)
  ) u_wr_gray2bin (
    .gray (rd.sync_wr_ptr),
    .bin  (wr_bin)
  );

  // NOTE: every signal driven here gets a value on every path, so no latch
  // is inferred; keep it that way when adding terms.
  always_comb begin
    comb_gray   = ptr_t'(bin2gray(gray_word_t'(r_ptr_q)));
    // Exact Gray match over all bits: the extra MSB separates empty from full.
    empty_c     = (comb_gray == rd.sync_wr_ptr);
    comb_count  = wr_bin - r_ptr_q;
    rd_accept   = rd.r_inc && !empty_c;
    r_ptr_d     = rd_accept ? (r_ptr_q + PTR_ONE) : r_ptr_q;
    gray_d      = comb_gray;
    count_d     = comb_count;
    underflow_d = rd.r_inc && empty_c;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge r_clk or negedge r_rstn) begin
    if (!r_rstn) begin
      r_ptr_q     <= '0;
      gray_q      <= '0;
      count_q     <= '0;
      underflow_q <= 1'b0;
    end else begin
      r_ptr_q     <= r_ptr_d;
      gray_q      <= gray_d;
      count_q     <= count_d;
      underflow_q <= underflow_d;
    end
  end

  assign rd.r_addr       = r_ptr_q[P_SIZE-2:0];
  assign rd.gray_rd_ptr  = gray_q;
  assign rd.empty        = empty_c;
  assign rd.almost_empty = (comb_count <= AE_THRESH);
  assign rd.rd_count     = count_q;
  assign rd.underflow    = underflow_q;

endmodule

// File: tb/tb_fifo_rd.sv
// Self-checking bench for fifo_rd (P_SIZE=4, AE_LEVEL=1): a reference model
// pushes expected outputs per clock into a queue that each scenario pops and compares.
module tb_fifo_rd;

  localparam int P  = 4;
  localparam int AE = 1;

  localparam logic [3:0] GRAY_TAB [16] = '{
    4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
    4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8
  };

  logic r_clk = 1'b0;
  logic r_rstn;

  fifo_rd_if #(.P_SIZE(P)) bus ();

  fifo_rd #(
    .P_SIZE   (P),
    .AE_LEVEL (AE)
  ) dut (
    .r_clk  (r_clk),
    .r_rstn (r_rstn),
    .rd     (bus)
  );

  always #5 r_clk = ~r_clk;

  typedef struct packed {
    logic [2:0] addr;
    logic [3:0] gray;
    logic [3:0] count;
    logic       uf;
    logic       empty;
    logic       ae;
  } obs_t;

  obs_t sb_q[$];
  int   total = 0;
  int   bad   = 0;

  int         m_ptr;
  logic [3:0] m_gray;
  logic [3:0] m_count;
  logic       m_uf;

  function automatic int g2b(input logic [3:0] g);
    int b = 0;
    for (int i = 0; i < 4; i++) b |= int'(^(g >> i)) << i;
    return b;
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o.addr  = bus.r_addr;
    o.gray  = bus.gray_rd_ptr;
    o.count = bus.rd_count;
    o.uf    = bus.underflow;
    o.empty = bus.empty;
    o.ae    = bus.almost_empty;
    return o;
  endfunction

  function automatic string fmt(input obs_t o);
    return $sformatf("addr=%0d gray=%b cnt=%0d uf=%b empty=%b ae=%b",
                     o.addr, o.gray, o.count, o.uf, o.empty, o.ae);
  endfunction

  function automatic obs_t model_view();
    obs_t o;
    int   cnt;
    cnt     = (g2b(bus.sync_wr_ptr) - m_ptr) & 15;
    o.addr  = 3'(m_ptr & 7);
    o.gray  = m_gray;
    o.count = m_count;
    o.uf    = m_uf;
    o.empty = (cnt == 0);
    o.ae    = (cnt <= AE);
    return o;
  endfunction

  // Drive one clock with the given read request; the model's post-edge view is queued.
  task automatic cycle(input bit inc);
    int cnt;
    bit emp;
    bus.r_inc = inc;
    cnt     = (g2b(bus.sync_wr_ptr) - m_ptr) & 15;
    emp     = (cnt == 0);
    m_gray  = GRAY_TAB[m_ptr];
    m_count = 4'(cnt);
    m_uf    = inc && emp;
    if (inc && !emp) m_ptr = (m_ptr + 1) & 15;
    sb_q.push_back(model_view());
    @(posedge r_clk);
    #1;
  endtask

  task automatic model_reset();
    m_ptr   = 0;
    m_gray  = '0;
    m_count = '0;
    m_uf    = 1'b0;
    sb_q.delete();
  endtask

  task automatic apply_reset();
    r_rstn          = 1'b0;
    bus.r_inc       = 1'b0;
    bus.sync_wr_ptr = '0;
    model_reset();
    repeat (2) @(posedge r_clk);
    #3 r_rstn = 1'b1;
    @(posedge r_clk);
    #1;
  endtask

  task automatic test_reset();
    obs_t got, want;
    apply_reset();
    want = '{addr: 3'd0, gray: 4'b0000, count: 4'd0, uf: 1'b0, empty: 1'b1, ae: 1'b1};
    got  = sample();
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL reset_state: got %s want %s", fmt(got), fmt(want));
    end
  endtask

  task automatic test_read3();
    obs_t got, want;
    bus.sync_wr_ptr = 4'b0010;
    #1;
    total++;
    if ({bus.empty, bus.almost_empty} !== 2'b00) begin
      bad++;
      $display("FAIL read3_comb_flags: got empty=%b ae=%b want 0 0", bus.empty, bus.almost_empty);
    end
    cycle(1'b0);
    got = sample(); want = sb_q.pop_front(); total++;
    if (got !== want) begin
      bad++;
      $display("FAIL read3_load: got %s want %s", fmt(got), fmt(want));
    end
    total++;
    if (bus.rd_count !== 4'd3) begin
      bad++;
      $display("FAIL read3_count: got %0d want 3", bus.rd_count);
    end
    for (int i = 1; i <= 3; i++) begin
      cycle(1'b1);
      got = sample(); want = sb_q.pop_front(); total++;
      if (got !== want) begin
        bad++;
        $display("FAIL read3_step%0d: got %s want %s", i, fmt(got), fmt(want));
      end
      total++;
      if (bus.r_addr !== 3'(i)) begin
        bad++;
        $display("FAIL read3_addr%0d: got %0d want %0d", i, bus.r_addr, i);
      end
      if (i == 2) begin
        total++;
        if ({bus.empty, bus.almost_empty} !== 2'b01) begin
          bad++;
          $display("FAIL read3_ae_one_left: got empty=%b ae=%b want 0 1", bus.empty, bus.almost_empty);
        end
      end
    end
    total++;
    if (bus.empty !== 1'b1) begin
      bad++;
      $display("FAIL read3_empty: got %b want 1", bus.empty);
    end
    cycle(1'b0);
    got = sample(); want = sb_q.pop_front(); total++;
    if (got !== want) begin
      bad++;
      $display("FAIL read3_settle: got %s want %s", fmt(got), fmt(want));
    end
    total++;
    if (bus.gray_rd_ptr !== 4'b0010) begin
      bad++;
      $display("FAIL read3_gray: got %b want 0010", bus.gray_rd_ptr);
    end
  endtask

  task automatic test_underflow();
    obs_t got, want;
    for (int i = 0; i < 3; i++) begin
      cycle(i < 2);
      got = sample(); want = sb_q.pop_front(); total++;
      if (got !== want) begin
        bad++;
        $display("FAIL underflow_cyc%0d: got %s want %s", i, fmt(got), fmt(want));
      end
      total++;
      if ({bus.underflow, bus.r_addr} !== {(i < 2) ? 1'b1 : 1'b0, 3'd3}) begin
        bad++;
        $display("FAIL underflow_pulse%0d: got uf=%b addr=%0d want uf=%b addr=3",
                 i, bus.underflow, bus.r_addr, (i < 2));
      end
    end
  endtask

  task automatic test_wrap();
    obs_t got, want;
    bus.sync_wr_ptr = 4'b0100;
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1);
      got = sample(); want = sb_q.pop_front(); total++;
      if (got !== want) begin
        bad++;
        $display("FAIL wrap_advance%0d: got %s want %s", i, fmt(got), fmt(want));
      end
    end
    bus.sync_wr_ptr = 4'b1101;
    cycle(1'b0);
    got = sample(); want = sb_q.pop_front(); total++;
    if (got !== want) begin
      bad++;
      $display("FAIL wrap_load: got %s want %s", fmt(got), fmt(want));
    end
    total++;
    if ({bus.rd_count, bus.r_addr, bus.gray_rd_ptr} !== {4'd2, 3'd7, 4'b0100}) begin
      bad++;
      $display("FAIL wrap_start: got cnt=%0d addr=%0d gray=%b want cnt=2 addr=7 gray=0100",
               bus.rd_count, bus.r_addr, bus.gray_rd_ptr);
    end
    cycle(1'b1);
    got = sample(); want = sb_q.pop_front(); total++;
    if (got !== want) begin
      bad++;
      $display("FAIL wrap_read1: got %s want %s", fmt(got), fmt(want));
    end
    total++;
    if (bus.r_addr !== 3'd0) begin
      bad++;
      $display("FAIL wrap_addr: got %0d want 0", bus.r_addr);
    end
    cycle(1'b1);
    got = sample(); want = sb_q.pop_front(); total++;
    if (got !== want) begin
      bad++;
      $display("FAIL wrap_read2: got %s want %s", fmt(got), fmt(want));
    end
    total++;
    if ({bus.gray_rd_ptr, bus.empty} !== {4'b1100, 1'b1}) begin
      bad++;
      $display("FAIL wrap_end: got gray=%b empty=%b want gray=1100 empty=1",
               bus.gray_rd_ptr, bus.empty);
    end
    cycle(1'b0);
    got = sample(); want = sb_q.pop_front(); total++;
    if (got !== want) begin
      bad++;
      $display("FAIL wrap_idle: got %s want %s", fmt(got), fmt(want));
    end
  endtask

  task automatic test_full();
    obs_t got, want;
    apply_reset();
    bus.sync_wr_ptr = 4'b1100;
    cycle(1'b0);
    got = sample(); want = sb_q.pop_front(); total++;
    if (got !== want) begin
      bad++;
      $display("FAIL full_model: got %s want %s", fmt(got), fmt(want));
    end
    total++;
    if ({bus.rd_count, bus.empty, bus.almost_empty} !== {4'd8, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL full_flags: got cnt=%0d empty=%b ae=%b want cnt=8 empty=0 ae=0",
               bus.rd_count, bus.empty, bus.almost_empty);
    end
  endtask

  task automatic test_reset_mid_burst();
    obs_t got, want;
    for (int i = 0; i < 2; i++) begin
      cycle(1'b1);
      got = sample(); want = sb_q.pop_front(); total++;
      if (got !== want) begin
        bad++;
        $display("FAIL burst_read%0d: got %s want %s", i, fmt(got), fmt(want));
      end
    end
    bus.r_inc = 1'b1;
    #2 r_rstn = 1'b0;
    #1;
    model_reset();
    total++;
    if ({bus.r_addr, bus.gray_rd_ptr, bus.rd_count, bus.underflow} !== 12'd0) begin
      bad++;
      $display("FAIL burst_async_reset: got addr=%0d gray=%b cnt=%0d uf=%b want all 0",
               bus.r_addr, bus.gray_rd_ptr, bus.rd_count, bus.underflow);
    end
    @(posedge r_clk);
    #2 r_rstn = 1'b1;
    total++;
    if (bus.r_addr !== 3'd0) begin
      bad++;
      $display("FAIL burst_first_addr: got %0d want 0", bus.r_addr);
    end
    for (int i = 0; i < 2; i++) begin
      cycle(i == 0);
      got = sample(); want = sb_q.pop_front(); total++;
      if (got !== want) begin
        bad++;
        $display("FAIL burst_after_reset%0d: got %s want %s", i, fmt(got), fmt(want));
      end
    end
  endtask

  initial begin
    r_rstn          = 1'b0;
    bus.r_inc       = 1'b0;
    bus.sync_wr_ptr = '0;
    test_reset();
    test_read3();
    test_underflow();
    test_wrap();
    test_full();
    test_reset_mid_burst();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
